// File: rtl/ffn_pkg.sv
// Shared types and default sizing for the FFN output stage.
package ffn_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ACC_WIDTH_DEF  = 64;
   localparam int NEURON_NUM_DEF = 4;
   localparam int FRAC_BITS_DEF  = 8;

   localparam logic signed [DATA_WIDTH_DEF-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
   localparam logic signed [DATA_WIDTH_DEF-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EMIT
   } state_e;

endpackage

// File: rtl/ffn_requant.sv
// Combinational requantiser: round-half-up, rescale, bias, optional ReLU, saturate.
module ffn_requant
   import ffn_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
   input  logic signed [ACC_WIDTH-1:0]  acc,
   input  logic signed [DATA_WIDTH-1:0] bias,
   input  logic                         relu_en,
   output logic        [DATA_WIDTH-1:0] data,
   output logic                         sat
);

   localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
   localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(FRAC_BITS > 0) << RND_SH;
   localparam logic signed [ACC_WIDTH+1:0] SAT_MAX =
      {{(ACC_WIDTH+3-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH+1:0] SAT_MIN =
      {{(ACC_WIDTH+3-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH:0]   r, s;
   logic signed [ACC_WIDTH+1:0] t, t_relu;

   // Widths grow by one bit per add so no intermediate step can wrap
   always_comb begin
      r      = {acc[ACC_WIDTH-1], acc} + RND;
      s      = r >>> FRAC_BITS;
      t      = {s[ACC_WIDTH], s} + {{(ACC_WIDTH+2-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
      t_relu = (relu_en && t[ACC_WIDTH+1]) ? '0 : t;
      sat    = 1'b0;
      data   = t_relu[DATA_WIDTH-1:0];
      if (t_relu > SAT_MAX) begin
         data = SAT_MAX[DATA_WIDTH-1:0];
         sat  = 1'b1;
      end else if (t_relu < SAT_MIN) begin
         data = SAT_MIN[DATA_WIDTH-1:0];
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/ffn_output_stage.sv
// Captures one accumulator vector and streams requantised neurons one per beat.
module ffn_output_stage
   import ffn_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int NEURON_NUM = NEURON_NUM_DEF,
   parameter int FRAC_BITS  = FRAC_BITS_DEF,
   parameter int IDX_WIDTH  = $clog2(NEURON_NUM)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ACC_WIDTH*NEURON_NUM-1:0]  acc_i,
   input  logic                             acc_valid_i,
   output logic                             acc_ready_o,
   input  logic [DATA_WIDTH*NEURON_NUM-1:0] bias_i,
   input  logic                             relu_en_i,
   output logic [DATA_WIDTH-1:0]            out_data_o,
   output logic [IDX_WIDTH-1:0]             out_idx_o,
   output logic                             out_last_o,
   output logic                             out_sat_o,
   output logic                             out_valid_o,
   input  logic                             out_ready_i
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NEURON_NUM - 1);

   state_e                               state_q, state_d;
   logic [IDX_WIDTH-1:0]                 idx_q, sel_idx;
   logic [NEURON_NUM-1:0][ACC_WIDTH-1:0]  acc_q;
   logic [NEURON_NUM-1:0][DATA_WIDTH-1:0] bias_q;
   logic                                 relu_q;
   logic [ACC_WIDTH-1:0]                 sel_acc;
   logic [DATA_WIDTH-1:0]                sel_bias, rq_data;
   logic                                 rq_sat, accept, advance, load_beat;

   assign acc_ready_o = (state_q == IDLE);
   assign out_idx_o   = idx_q;
   assign accept      = out_valid_o & out_ready_i;
   assign advance     = (state_q == EMIT) & accept & (idx_q != LAST_IDX);
   assign load_beat   = (state_q == LOAD) | advance;

   // While emitting, the requantiser looks one neuron ahead so an accept reloads on the same edge
   assign sel_idx = (state_q == EMIT) ? idx_q + 1'b1 : idx_q;

   // Neuron 0 sits in the MSBs of the packed vectors
   always_comb begin
      sel_acc  = '0;
      sel_bias = '0;
      for (int n = 0; n < NEURON_NUM; n++) begin
         if (sel_idx == IDX_WIDTH'(n)) begin
            sel_acc  = acc_q[NEURON_NUM-1-n];
            sel_bias = bias_q[NEURON_NUM-1-n];
         end
      end
   end

   ffn_requant #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
   ) u_requant (
      .acc     (sel_acc),
      .bias    (sel_bias),
      .relu_en (relu_q),
      .data    (rq_data),
      .sat     (rq_sat)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (acc_valid_i) state_d = LOAD;
         LOAD:    state_d = EMIT;
         EMIT:    if (accept && idx_q == LAST_IDX) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         bias_q      <= '0;
         relu_q      <= 1'b0;
         out_data_o  <= '0;
         out_last_o  <= 1'b0;
         out_sat_o   <= 1'b0;
         out_valid_o <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && acc_valid_i) begin
            acc_q  <= acc_i;
            bias_q <= bias_i;
            relu_q <= relu_en_i;
            idx_q  <= '0;
         end
         if (advance) idx_q <= idx_q + 1'b1;
         if (load_beat) begin
            out_data_o  <= rq_data;
            out_sat_o   <= rq_sat;
            out_last_o  <= (sel_idx == LAST_IDX);
            out_valid_o <= 1'b1;
         end else if (state_q == EMIT && accept) begin
            out_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ffn_output_stage.sv
// Directed and randomized bench for ffn_output_stage against a plain-arithmetic reference.
module tb_ffn_output_stage;

   localparam int DW = 16;
   localparam int AW = 64;
   localparam int NN = 4;
   localparam int IW = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [AW*NN-1:0]     acc_i;
   logic                 acc_valid_i;
   logic                 acc_ready_o;
   logic [DW*NN-1:0]     bias_i;
   logic                 relu_en_i;
   logic [DW-1:0]        out_data_o;
   logic [IW-1:0]        out_idx_o;
   logic                 out_last_o;
   logic                 out_sat_o;
   logic                 out_valid_o;
   logic                 out_ready_i;

   int checks   = 0;
   int failures = 0;

   logic signed [AW-1:0] va[NN];
   logic signed [DW-1:0] vb[NN];
   bit                   vr;

   ffn_output_stage dut (
      .clk         (clk),
      .rst         (rst),
      .acc_i       (acc_i),
      .acc_valid_i (acc_valid_i),
      .acc_ready_o (acc_ready_o),
      .bias_i      (bias_i),
      .relu_en_i   (relu_en_i),
      .out_data_o  (out_data_o),
      .out_idx_o   (out_idx_o),
      .out_last_o  (out_last_o),
      .out_sat_o   (out_sat_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: floor((acc + 2^7) / 2^8) + bias, ReLU, then clamp to int16
   function automatic void ref_beat(input logic signed [AW-1:0] a, input logic signed [DW-1:0] b,
                                    input bit relu, output logic [DW-1:0] d, output bit sat);
      logic signed [127:0] v;
      v = a;
      v = (v + 128) >>> 8;
      v = v + b;
      if (relu && v < 0) v = 0;
      sat = 1'b0;
      if (v > 32767) begin
         d = 16'h7fff; sat = 1'b1;
      end else if (v < -32768) begin
         d = 16'h8000; sat = 1'b1;
      end else begin
         d = v[DW-1:0];
      end
   endfunction

   task automatic scramble();
      for (int w = 0; w < AW*NN/32; w++) acc_i[32*w +: 32] = $urandom;
      bias_i = {$urandom, $urandom};
   endtask

   task automatic pack();
      for (int n = 0; n < NN; n++) begin
         acc_i[AW*(NN-n)-1 -: AW]  = va[n];
         bias_i[DW*(NN-n)-1 -: DW] = vb[n];
      end
      relu_en_i = vr;
   endtask

   // mode 0: ready always high; 1: random ready; 2: ready low for 3 cycles at idx 1
   task automatic run_vec(input int mode, input string tag);
      logic [DW-1:0] ed[NN];
      bit            es[NN];
      int            k, lowcnt, cyc;
      bit            acc_ok;
      for (int n = 0; n < NN; n++) ref_beat(va[n], vb[n], vr, ed[n], es[n]);
      chk({tag, " idle_ready"}, acc_ready_o, 1);
      pack();
      acc_valid_i = 1'b1;
      out_ready_i = 1'b1;
      step();
      acc_valid_i = 1'b0;
      scramble();
      relu_en_i = ~vr;
      chk({tag, " load_valid"}, out_valid_o, 0);
      chk({tag, " load_ready"}, acc_ready_o, 0);
      step();
      chk({tag, " first_valid"}, out_valid_o, 1);
      k = 0; lowcnt = 0; cyc = 0;
      while (k < NN && cyc < 200) begin
         case (mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = 1'($urandom_range(0, 1));
            default: begin
               out_ready_i = !(k == 1 && lowcnt < 3);
               if (k == 1 && lowcnt < 3) lowcnt++;
            end
         endcase
         acc_valid_i = 1'($urandom_range(0, 1));
         scramble();
         chk({tag, " valid"}, out_valid_o, 1);
         if (!out_valid_o) break;
         chk({tag, " data"}, out_data_o, ed[k]);
         chk({tag, " idx"}, out_idx_o, k);
         chk({tag, " last"}, out_last_o, (k == NN-1));
         chk({tag, " sat"}, out_sat_o, es[k]);
         chk({tag, " busy_ready"}, acc_ready_o, 0);
         acc_ok = out_ready_i;
         step();
         if (acc_ok) k++;
         cyc++;
      end
      acc_valid_i = 1'b0;
      out_ready_i = 1'b0;
      chk({tag, " beats"}, k, NN);
      if (mode == 0) chk({tag, " cycles"}, cyc, NN);
      if (mode == 2) chk({tag, " held"}, lowcnt, 3);
      chk({tag, " end_valid"}, out_valid_o, 0);
      chk({tag, " end_ready"}, acc_ready_o, 1);
   endtask

   initial begin
      logic [63:0] tmp;
      rst = 1'b1; acc_valid_i = 1'b0; out_ready_i = 1'b0; relu_en_i = 1'b0;
      acc_i = '0; bias_i = '0;
      step(); step();
      chk("rst valid", out_valid_o, 0);
      chk("rst ready", acc_ready_o, 1);
      chk("rst data", out_data_o, 0);
      chk("rst idx", out_idx_o, 0);
      chk("rst last", out_last_o, 0);
      chk("rst sat", out_sat_o, 0);
      rst = 1'b0;
      step();

      va = '{256, 512, -256, 0};   vb = '{0, 0, 0, 0}; vr = 0;
      run_vec(0, "basic");
      va = '{384, 383, -384, -385}; vb = '{0, 0, 0, 0}; vr = 0;
      run_vec(1, "round");
      va = '{64'sd1 <<< 24, -(64'sd1 <<< 40), 64'sd32767 * 256, 256};
      vb = '{0, 0, 1, -3}; vr = 0;
      run_vec(2, "satbias");
      va = '{-512, -512, -512, -512}; vb = '{1, 1, 1, 1}; vr = 1;
      run_vec(0, "relu_on");
      vr = 0;
      run_vec(1, "relu_off");

      // reset while idx 2 is on the output
      va = '{1000, 2000, 3000, 4000}; vb = '{5, 6, 7, 8}; vr = 0;
      pack();
      acc_valid_i = 1'b1; out_ready_i = 1'b1;
      step();
      acc_valid_i = 1'b0;
      step(); step(); step();
      chk("mid idx", out_idx_o, 2);
      chk("mid valid", out_valid_o, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready_i = 1'b0;
      chk("mid rst valid", out_valid_o, 0);
      chk("mid rst ready", acc_ready_o, 1);
      va = '{-70000, 70000, 1 <<< 20, -(1 <<< 20)}; vb = '{-100, 100, 0, 0}; vr = 0;
      run_vec(0, "after_rst");

      for (int i = 0; i < 12; i++) begin
         for (int n = 0; n < NN; n++) begin
            tmp   = {$urandom, $urandom};
            va[n] = $signed(tmp) >>> $urandom_range(0, 62);
            vb[n] = DW'($urandom);
         end
         vr = 1'($urandom_range(0, 1));
         run_vec(i % 3, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ffn_output_stage.md
Name: ffn_output_stage

Overview:
- Downstream consumer of the 4x4 systolic array's packed accumulator vector (one ACC_WIDTH result per neuron).
- Captures one vector through a valid/ready handshake, then processes one neuron per beat: rounds, rescales the fixed-point result, adds the per-neuron bias, applies optional ReLU and saturates to DATA_WIDTH.
- Streams the neuron results out one per beat with a valid/ready handshake toward the next FFN layer or the writeback buffer.

Parameters:
- DATA_WIDTH, 16: output and bias word width, signed fixed point.
- ACC_WIDTH, 64: per-neuron accumulator width, signed.
- NEURON_NUM, 4: neurons per captured vector.
- FRAC_BITS, 8: arithmetic right shift that rescales the accumulator into output fixed point. Legal range is 0..ACC_WIDTH-2.
- IDX_WIDTH, $clog2(NEURON_NUM): width of the neuron index.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- acc_i  in  ACC_WIDTH*NEURON_NUM  packed accumulators. Neuron n is at [ACC_WIDTH*(NEURON_NUM-n)-1 -: ACC_WIDTH], so neuron 0 is in the MSBs.
- acc_valid_i  in  1  acc_i, bias_i and relu_en_i are valid.
- acc_ready_o  out  1  block can capture a vector.
- bias_i  in  DATA_WIDTH*NEURON_NUM  per-neuron bias, packed the same way as acc_i.
- relu_en_i  in  1  apply ReLU to this vector.
- out_data_o  out  DATA_WIDTH  result for the current neuron.
- out_idx_o  out  IDX_WIDTH  neuron index of the current beat.
- out_last_o  out  1  current beat is neuron NUM-1.
- out_sat_o  out  1  current beat was clipped by saturation.
- out_valid_o  out  1  beat valid.
- out_ready_i  in  1  consumer accepts the beat.

Behaviour:
- Reset. Synchronous; all outputs are 0 except acc_ready_o=1. State goes to IDLE, idx=0, and the capture registers are cleared.
- FSM states: IDLE, LOAD, EMIT.
- IDLE:
  - acc_ready_o=1.
  - When acc_valid_i=1, register acc_i, bias_i and relu_en_i, set idx=0 and go to LOAD.
- LOAD:
  - acc_ready_o=0.
  - Compute neuron 0 into the output registers, set out_valid_o=1 and go to EMIT.
  - First beat is valid 2 cycles after the capture edge.
- EMIT:
  - out_valid_o=1; out_data_o, out_idx_o, out_last_o and out_sat_o are all held stable until accepted.
  - On accept (out_valid_o & out_ready_i) with idx<NUM-1: idx increments and the next neuron is loaded on the same edge, so out_valid_o stays high (1 beat/cycle under continuous ready).
  - On accept with idx=NUM-1: out_valid_o=0 and the FSM returns to IDLE. acc_ready_o=1 the next cycle; no overlap of capture and emit.
- Arithmetic, per neuron, with no intermediate overflow permitted:
  - Round: r = acc + (FRAC_BITS>0 ? 2^(FRAC_BITS-1) : 0), in ACC_WIDTH+1 bits. This is round-half-up.
  - Scale: s = r >>> FRAC_BITS (arithmetic shift).
  - Bias: t = s + sign-extended bias, in ACC_WIDTH+2 bits.
  - ReLU: if relu_en is set and t<0, then t=0.
  - Saturate: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. out_sat_o=1 only when the clamp changes the value; ReLU zeroing is not saturation.
- Boundaries:
  - acc_valid_i while not in IDLE: ignored, no handshake, no capture.
  - out_ready_i while out_valid_o=0: no effect.
  - bias_i and relu_en_i changes after capture: no effect on the in-flight vector.
  - rst during LOAD or EMIT: pending beats are discarded; the next cycle shows out_valid_o=0 and acc_ready_o=1.

Decomposition:
- Package ffn_pkg holds:
  - the state enum typedef (IDLE/LOAD/EMIT);
  - the DATA_WIDTH/ACC_WIDTH/NEURON_NUM defaults as shared localparams;
  - the signed min/max constants derived from DATA_WIDTH.
- Sub-module ffn_requant (combinational): acc, bias, relu_en -> data, sat. This keeps the arithmetic unit-testable and reusable.

Test Plan (DATA_WIDTH=16, FRAC_BITS=8, NEURON_NUM=4):
1. Basic stream. acc={256,512,-256,0}, bias=0, relu=0, out_ready=1 -> beats 1,2,-1,0 with idx 0..3 on 4 consecutive cycles. First beat valid 2 cycles after capture; out_last only on idx 3.
2. Rounding. acc=384 -> 2; acc=383 -> 1; acc=-384 -> -1; acc=-385 -> -2; bias=0.
3. Saturation and bias.
   - acc=2^24 -> 32767 with sat=1.
   - acc=-2^40 -> -32768 with sat=1.
   - acc=32767*256, bias=1 -> 32767 with sat=1.
   - acc=256, bias=-3 -> -2 with sat=0.
4. ReLU. acc=-512, bias=1: relu=1 -> 0 with sat=0; relu=0 -> -1.
5. Backpressure.
   - out_ready low for 3 cycles at idx 1 -> data and idx held, no beat lost or duplicated.
   - acc_valid pulsed during EMIT -> acc_ready=0 and no capture; the stream is unchanged.
6. Reset mid-stream. rst at idx 2 -> next cycle out_valid=0, acc_ready=1. A new vector then streams correctly starting at idx 0.
